// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker: locks onto a +1/-1 counter sequence and flags every break after lock.
// Define CNT_CHK_SVA_EN to compile the protocol assertions and covers.
module cnt_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int INC_DEC  = 1,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_vld,
    input  logic             resync,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] exp_cnt
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    localparam logic [WIDTH-1:0] STEP   = INC_DEC != 0 ? WIDTH'(1) : {WIDTH{1'b1}};
    localparam logic [7:0]       LOCK_N = 8'(LOCK_CNT);

    state_t           state_q, state_d;
    logic [7:0]       match_q, match_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             sample, hit, brk, lock_now;

    // resync drops a same-cycle sample entirely
    assign sample   = cnt_vld & ~resync;
    assign hit      = cnt_in == exp_q;
    assign brk      = sample & (state_q == LOCKED) & ~hit;
    assign lock_now = sample & (state_q == ACQ) & hit & (match_q + 8'd1 == LOCK_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            match_q     <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            exp_q       <= exp_d;
        end
    end

    always_comb begin
        state_d = resync             ? IDLE :
                  !cnt_vld           ? state_q :
                  state_q == IDLE    ? ACQ :
                  state_q == ACQ     ? (lock_now ? LOCKED : ACQ) :
                                       (hit ? LOCKED : ACQ);
    end

    always_comb begin
        exp_d       = sample ? cnt_in + STEP : exp_q;
        match_d     = resync                          ? 8'd0 :
                      !cnt_vld                        ? match_q :
                      (state_q == ACQ) && hit         ? match_q + 8'd1 :
                      (state_q == LOCKED) && hit      ? match_q : 8'd0;
        locked_d    = state_d == LOCKED;
        err_pulse_d = brk;
        err_cnt_d   = err_clr              ? '0 :
                      brk && !(&err_cnt_q) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign exp_cnt   = exp_q;

`ifdef CNT_CHK_SVA_EN
    ap_no_double_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        err_pulse_q |=> !err_pulse_q)
        else $error("ap_no_double_pulse failed at %0t", $time);
    cp_no_double_pulse: cover property (@(posedge clk) disable iff (!rst_n)
        err_pulse_q ##1 !err_pulse_q);

    ap_pulse_after_lock: assert property (@(posedge clk) disable iff (!rst_n)
        err_pulse_q |-> $past(locked_q))
        else $error("ap_pulse_after_lock failed at %0t", $time);
    cp_pulse_after_lock: cover property (@(posedge clk) disable iff (!rst_n)
        err_pulse_q);

    ap_lock_after_n: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(locked_q) |-> $past(state_q == ACQ && sample && hit && match_q == LOCK_N - 8'd1))
        else $error("ap_lock_after_n failed at %0t", $time);
    cp_lock_after_n: cover property (@(posedge clk) disable iff (!rst_n)
        $rose(locked_q));

    ap_cnt_known: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_vld |-> !$isunknown(cnt_in))
        else $error("ap_cnt_known failed at %0t", $time);
    cp_cnt_known: cover property (@(posedge clk) disable iff (!rst_n)
        cnt_vld);

    ap_err_monotonic: assert property (@(posedge clk) disable iff (!rst_n)
        (err_cnt_q < $past(err_cnt_q)) |-> $past(err_clr))
        else $error("ap_err_monotonic failed at %0t", $time);
    cp_err_monotonic: cover property (@(posedge clk) disable iff (!rst_n)
        err_cnt_q > $past(err_cnt_q));
`endif
endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb_cnt_seq_checker: directed vectors against an up/LOCK_CNT=4/ERR_W=2 instance
// and a down/LOCK_CNT=1 instance.
module tb_cnt_seq_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_cnt = '0, b_cnt = '0;
    logic       a_vld = 1'b0, a_rs = 1'b0, a_clr = 1'b0;
    logic       b_vld = 1'b0, b_rs = 1'b0, b_clr = 1'b0;
    logic       a_lock, a_ep, b_lock, b_ep;
    logic [1:0] a_ec;
    logic [7:0] b_ec, a_exp, b_exp;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    cnt_seq_checker #(.WIDTH(8), .INC_DEC(1), .LOCK_CNT(4), .ERR_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .cnt_in(a_cnt), .cnt_vld(a_vld), .resync(a_rs),
        .err_clr(a_clr), .locked(a_lock), .err_pulse(a_ep), .err_cnt(a_ec), .exp_cnt(a_exp));

    cnt_seq_checker #(.WIDTH(8), .INC_DEC(0), .LOCK_CNT(1), .ERR_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .cnt_in(b_cnt), .cnt_vld(b_vld), .resync(b_rs),
        .err_clr(b_clr), .locked(b_lock), .err_pulse(b_ep), .err_cnt(b_ec), .exp_cnt(b_exp));

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // inputs change 1 time unit after the edge; outputs are read there too
    task automatic drv_a(input logic [7:0] v, input logic vld = 1'b1, input logic rs = 1'b0, input logic clr = 1'b0);
        a_cnt = v; a_vld = vld; a_rs = rs; a_clr = clr;
        @(posedge clk); #1;
        a_vld = 1'b0; a_rs = 1'b0; a_clr = 1'b0;
    endtask

    task automatic drv_b(input logic [7:0] v);
        b_cnt = v; b_vld = 1'b1;
        @(posedge clk); #1;
        b_vld = 1'b0;
    endtask

    initial begin
        @(posedge clk); @(posedge clk); #1;
        chk("rst_locked", a_lock, 0);
        chk("rst_pulse", a_ep, 0);
        chk("rst_errcnt", a_ec, 0);
        chk("rst_exp", a_exp, 0);
        rst_n = 1'b1;

        // down counter, single-step lock, wrap 0x00 -> 0xFF
        drv_b(8'h01);
        chk("b_first_locked", b_lock, 0);
        chk("b_first_exp", b_exp, 8'h00);
        drv_b(8'h00);
        chk("b_lock1", b_lock, 1);
        drv_b(8'hFF);
        chk("b_wrap_pulse", b_ep, 0);
        chk("b_wrap_locked", b_lock, 1);
        chk("b_wrap_exp", b_exp, 8'hFE);
        drv_b(8'h05);
        chk("b_brk_pulse", b_ep, 1);
        chk("b_brk_cnt", b_ec, 1);
        chk("b_brk_locked", b_lock, 0);

        // lock on increment
        for (int i = 0; i < 4; i++) drv_a(8'h10 + 8'(i));
        chk("lock_early", a_lock, 0);
        drv_a(8'h14);
        chk("lock_inc", a_lock, 1);
        chk("lock_errcnt", a_ec, 0);
        chk("lock_exp", a_exp, 8'h15);

        // sequence break at 0x20
        for (int i = 'h15; i < 'h20; i++) drv_a(8'(i));
        chk("pre_brk_locked", a_lock, 1);
        drv_a(8'h30);
        chk("brk_pulse", a_ep, 1);
        chk("brk_errcnt", a_ec, 1);
        chk("brk_locked", a_lock, 0);
        chk("brk_exp", a_exp, 8'h31);
        drv_a(8'h00, 1'b0);
        chk("pulse_one_cycle", a_ep, 0);
        for (int i = 'h31; i < 'h34; i++) drv_a(8'(i));
        chk("relock_early", a_lock, 0);
        drv_a(8'h34);
        chk("relock", a_lock, 1);
        drv_a(8'h35);

        // gapped valid, then resync with a wrong value
        drv_a(8'h99, 1'b0);
        drv_a(8'h99, 1'b0);
        chk("gap_locked", a_lock, 1);
        chk("gap_exp", a_exp, 8'h36);
        drv_a(8'h36);
        chk("gap_resume", a_lock, 1);
        drv_a(8'h77, 1'b1, 1'b1);
        chk("rs_pulse", a_ep, 0);
        chk("rs_locked", a_lock, 0);
        chk("rs_errcnt", a_ec, 1);
        chk("rs_exp_hold", a_exp, 8'h37);
        drv_a(8'h50);
        chk("idle_sample_exp", a_exp, 8'h51);
        chk("idle_sample_pulse", a_ep, 0);

        // ACQ mismatch is not an error; lock then wrap 0xFF -> 0x00
        for (int i = 'hFA; i <= 'hFE; i++) drv_a(8'(i));
        chk("acq_no_err", a_ec, 1);
        chk("wrap_lock", a_lock, 1);
        drv_a(8'hFF);
        drv_a(8'h00);
        chk("wrap_pulse", a_ep, 0);
        drv_a(8'h01);
        chk("wrap_locked", a_lock, 1);
        chk("wrap_exp", a_exp, 8'h02);

        // reach err_cnt=2 while locked, then asynchronous reset mid-cycle
        drv_a(8'h40);
        chk("err2", a_ec, 2);
        for (int i = 'h41; i <= 'h44; i++) drv_a(8'(i));
        chk("err2_locked", a_lock, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked", a_lock, 0);
        chk("arst_errcnt", a_ec, 0);
        chk("arst_exp", a_exp, 0);
        chk("arst_b_errcnt", b_ec, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 'h45; i <= 'h48; i++) drv_a(8'(i));
        chk("arst_no_early_lock", a_lock, 0);
        drv_a(8'h49);
        chk("arst_relock", a_lock, 1);

        // saturation at 3, relocking between breaks
        for (int k = 0; k < 5; k++) begin
            drv_a(8'h60 + 8'(k * 16));
            chk("sat_pulse", a_ep, 1);
            chk("sat_cnt", a_ec, k < 3 ? k + 1 : 3);
            for (int j = 1; j <= 4; j++) drv_a(8'h60 + 8'(k * 16 + j));
            chk("sat_relock", a_lock, 1);
        end
        drv_a(8'hB0, 1'b1, 1'b0, 1'b1);
        chk("clr_pulse", a_ep, 1);
        chk("clr_wins", a_ec, 0);
        chk("clr_locked", a_lock, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cnt_seq_checker.md
Name: cnt_seq_checker

Overview:
Sink-side monitor for the free-running counter output. It samples a counter bus, acquires lock on the expected +1/-1 sequence, and flags every break in that sequence after lock. It sits beside any counter instance in a test harness or SoC debug path. It reports lock status, a one-cycle error pulse and a saturating error count.

Parameters:
WIDTH, 8, width of the monitored counter bus.
INC_DEC, 1, expected direction: 1 = each sample is previous +1; 0 = each sample is previous -1 (modulo 2^WIDTH).
LOCK_CNT, 4, consecutive correct steps required to declare lock; legal range 1..255.
ERR_W, 8, width of the error counter.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cnt_in  input  WIDTH  counter value under check
cnt_vld  input  1  cnt_in is sampled only on cycles where this is high
resync  input  1  synchronous restart of acquisition
err_clr  input  1  synchronous clear of err_cnt
locked  output  1  sequence lock achieved
err_pulse  output  1  one-cycle pulse per sequence break while locked
err_cnt  output  ERR_W  saturating count of sequence breaks
exp_cnt  output  WIDTH  value expected at the next valid sample

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Asserting rst_n low forces, at any point in operation:
  - state = IDLE
  - locked = 0, err_pulse = 0, err_cnt = 0, exp_cnt = 0
  - match counter = 0
- All outputs are registered. Effects appear on the clock edge that samples cnt_vld=1, i.e. visible the following cycle.
- Step value: +1 when INC_DEC=1, else -1. All arithmetic is modulo 2^WIDTH, so the wraps are legal steps:
  - INC_DEC=1: 0xFF -> 0x00 (WIDTH=8) is a match.
  - INC_DEC=0: 0x00 -> 0xFF is a match.
- State IDLE, on cnt_vld:
  - exp_cnt <= cnt_in + step; match = 0; go to ACQ.
- State ACQ, on cnt_vld:
  - Match (cnt_in == exp_cnt): match++. When match reaches LOCK_CNT, go to LOCKED and set locked=1.
  - Mismatch: match=0; stay in ACQ.
  - In both cases exp_cnt <= cnt_in + step.
  - No errors are counted in ACQ.
- State LOCKED, on cnt_vld:
  - Match: stay in LOCKED.
  - Mismatch: err_pulse=1 for exactly one cycle; err_cnt++ (saturating at all ones); locked=0; match=0; go to ACQ.
  - In both cases exp_cnt <= cnt_in + step, so re-acquisition starts from the failing value.
- Idle cycles: cycles with cnt_vld=0 hold all state and outputs, except err_pulse, which returns to 0.
- resync=1:
  - Next state is IDLE; locked=0; match=0; exp_cnt holds its value.
  - resync wins over a same-cycle cnt_vld; that sample is dropped and raises no error.
- err_clr=1: err_cnt <= 0.
  - If a same-cycle error occurs, err_pulse still fires but err_cnt ends at 0 (clear wins).
- LOCK_CNT=1: lock is declared on the first correct step after the first sample.

Optional Feature:
Macro: CNT_CHK_SVA_EN.
- When defined, the module compiles these concurrent assertions, each with a matching cover, all clocked on posedge clk and disabled while !rst_n:
  - err_pulse is never high on two consecutive cycles.
  - err_pulse implies that locked was 1 on the previous cycle.
  - locked rises only after exactly LOCK_CNT matching samples.
  - cnt_in is never unknown when cnt_vld=1.
  - err_cnt never decreases, except on err_clr.
- On failure, each assertion prints its name and $time.
- When the macro is undefined, no assertion or cover code is present. Functional RTL is identical in both cases.

Test Plan:
- Lock on increment: WIDTH=8, INC_DEC=1, LOCK_CNT=4; drive cnt_vld=1 with 0x10, 0x11, ..., 0x14 -> locked=1 the cycle after 0x14 is sampled; err_cnt=0; exp_cnt=0x15.
- Wrap-around: once locked, drive 0xFE, 0xFF, 0x00, 0x01 -> no err_pulse; locked stays 1. Repeat with INC_DEC=0 using 0x01, 0x00, 0xFF -> no error.
- Sequence break: while locked at 0x20, inject 0x30 -> err_pulse=1 for one cycle; err_cnt=1; locked=0. Then drive 0x31..0x35 -> locked=1 again after four matches.
- Gapped valid plus resync: interleave cnt_vld=0 cycles -> no state change. Assert resync together with cnt_vld carrying a wrong value -> no error; state IDLE; locked=0.
- Saturation and clear: ERR_W=2; force five breaks -> err_cnt stops at 3. Pulse err_clr in the same cycle as a break -> err_pulse=1 and err_cnt=0.
- Async reset mid-lock: drop rst_n between clock edges while locked with err_cnt=2 -> all outputs are 0 immediately; re-acquisition requires a fresh LOCK_CNT sequence.
